// File: rtl/nrisc_ddata_arbiter_pkg.sv
// Shared state, owner and size codes for the D-Data RAM arbiter.
// Optional feature macro used by the arbiter: NRISC_ARB_ROUND_ROBIN_EN.
package nrisc_ddata_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CORE   = 2'd1,
        ST_XBURST = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_XBUS = 2'd2
    } owner_t;

    localparam logic [2:0] CTRL_WORD = 3'b000;

endpackage

// File: rtl/nrisc_arb_burst_ctr.sv
// Saturating count of external grants given while the core waits;
// at_limit flags the last external grant allowed before the core must win.
module nrisc_arb_burst_ctr #(
    parameter int MAX_BURST = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int            CW    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(MAX_BURST - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_limit) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign at_limit = (cnt == LIMIT);

endmodule

// File: rtl/nrisc_ddata_arbiter.sv
// Shares the single-port D-Data RAM between the core and one external master.
// Define NRISC_ARB_ROUND_ROBIN_EN to alternate grants when both request.
module nrisc_ddata_arbiter
    import nrisc_ddata_arbiter_pkg::*;
#(
    parameter int TAM       = 16,
    parameter int N_DData   = 10,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               core_load,
    input  logic               core_write,
    input  logic [N_DData-1:0] core_addr,
    input  logic [TAM-1:0]     core_wdata,
    input  logic [2:0]         core_ctrl,
    output logic [TAM-1:0]     core_rdata,
    output logic               core_stall,
    input  logic               x_req,
    input  logic               x_we,
    input  logic [N_DData-1:0] x_addr,
    input  logic [TAM-1:0]     x_wdata,
    output logic               x_gnt,
    output logic [TAM-1:0]     x_rdata,
    output logic               x_rvalid,
    output logic [N_DData-1:0] mem_addr,
    output logic [TAM-1:0]     mem_wdata,
    output logic               mem_we,
    output logic               mem_re,
    output logic [2:0]         mem_ctrl,
    input  logic [TAM-1:0]     mem_rdata
);

    arb_state_t     state, state_nxt;
    owner_t         rd_owner;
    logic           core_req, grant_core, grant_x;
    logic           at_limit, burst_inc, burst_clr;
    logic [TAM-1:0] core_hold, x_hold;
`ifdef NRISC_ARB_ROUND_ROBIN_EN
    owner_t         last_owner;
`endif

    assign core_req = core_load | core_write;

    // Grants are gated by reset so nothing reaches the RAM while rst is low.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        grant_x = 1'b0;
        if (rst) begin
            if (state == ST_XBURST) begin
                grant_x = x_req;
            end else if (x_req) begin
`ifdef NRISC_ARB_ROUND_ROBIN_EN
                grant_x = !core_req || (last_owner == OWN_CORE);
`else
                grant_x = !core_req;
`endif
            end
        end
        grant_core = rst && core_req && !grant_x;
    end

    // An arbitrated external win while the core waits stays in CORE, so the
    // core is considered again on the very next cycle.
    always_comb begin
        state_nxt = ST_IDLE;
        if (grant_core) begin
            state_nxt = ST_CORE;
        end else if (grant_x) begin
            if (state == ST_XBURST) begin
                state_nxt = (core_req && at_limit) ? ST_CORE : ST_XBURST;
            end else begin
                state_nxt = core_req ? ST_CORE : ST_XBURST;
            end
        end
    end

    assign burst_inc = grant_x && core_req;
    assign burst_clr = (state_nxt != ST_XBURST);

    nrisc_arb_burst_ctr #(
        .MAX_BURST (MAX_BURST)
    ) u_burst_ctr (
        .clk      (clk),
        .rst      (rst),
        .inc      (burst_inc),
        .clr      (burst_clr),
        .at_limit (at_limit)
    );

    // A combined core load+write is a plain write; the load half is dropped.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_ctrl  = CTRL_WORD;
        if (grant_core) begin
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
            mem_we    = core_write;
            mem_re    = core_load && !core_write;
            mem_ctrl  = core_ctrl;
        end else if (grant_x) begin
            mem_addr  = x_addr;
            mem_wdata = x_wdata;
            mem_we    = x_we;
            mem_re    = !x_we;
        end
    end

    assign x_gnt      = grant_x;
    assign core_stall = rst && core_req && !grant_core;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            rd_owner   <= OWN_NONE;
            core_hold  <= '0;
            x_hold     <= '0;
`ifdef NRISC_ARB_ROUND_ROBIN_EN
            last_owner <= OWN_XBUS;
`endif
        end else begin
            state <= state_nxt;
            if (grant_core && core_load && !core_write) begin
                rd_owner <= OWN_CORE;
            end else if (grant_x && !x_we) begin
                rd_owner <= OWN_XBUS;
            end else begin
                rd_owner <= OWN_NONE;
            end
            if (rd_owner == OWN_CORE) core_hold <= mem_rdata;
            if (rd_owner == OWN_XBUS) x_hold    <= mem_rdata;
`ifdef NRISC_ARB_ROUND_ROBIN_EN
            if (grant_core) begin
                last_owner <= OWN_CORE;
            end else if (grant_x) begin
                last_owner <= OWN_XBUS;
            end
`endif
        end
    end

    // RAM data is forwarded in its return cycle, then held until the owner's next read.
    assign core_rdata = (rd_owner == OWN_CORE) ? mem_rdata : core_hold;
    assign x_rdata    = (rd_owner == OWN_XBUS) ? mem_rdata : x_hold;
    assign x_rvalid   = (rd_owner == OWN_XBUS);

endmodule

// File: tb/tb_nrisc_ddata_arbiter.sv
// Directed bench for nrisc_ddata_arbiter: cycle table plus multi-cycle sequences.
module tb_nrisc_ddata_arbiter;

`ifdef NRISC_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        core_load, core_write;
    logic [9:0]  core_addr;
    logic [15:0] core_wdata;
    logic [2:0]  core_ctrl;
    logic [15:0] core_rdata;
    logic        core_stall;
    logic        x_req, x_we;
    logic [9:0]  x_addr;
    logic [15:0] x_wdata;
    logic        x_gnt;
    logic [15:0] x_rdata;
    logic        x_rvalid;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we, mem_re;
    logic [2:0]  mem_ctrl;
    logic [15:0] mem_rdata = '0;

    logic [15:0] ram [0:1023];

    int checks   = 0;
    int failures = 0;

    nrisc_ddata_arbiter #(.TAM(16), .N_DData(10), .MAX_BURST(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .core_load  (core_load),
        .core_write (core_write),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_ctrl  (core_ctrl),
        .core_rdata (core_rdata),
        .core_stall (core_stall),
        .x_req      (x_req),
        .x_we       (x_we),
        .x_addr     (x_addr),
        .x_wdata    (x_wdata),
        .x_gnt      (x_gnt),
        .x_rdata    (x_rdata),
        .x_rvalid   (x_rvalid),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_ctrl   (mem_ctrl),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM model with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        logic        cl, cw;
        logic [9:0]  ca;
        logic [15:0] cwd;
        logic [2:0]  cc;
        logic        xr, xw;
        logic [9:0]  xa;
        logic [15:0] xwd;
        logic        e_xg, e_st, e_we, e_re;
        logic [9:0]  e_addr;
        logic [15:0] e_wd;
        logic [2:0]  e_ctrl;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        core_load  = 1'b0;
        core_write = 1'b0;
        core_addr  = '0;
        core_wdata = '0;
        core_ctrl  = '0;
        x_req      = 1'b0;
        x_we       = 1'b0;
        x_addr     = '0;
        x_wdata    = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Drive after the edge, sample at the following falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int xdone, gnt_wait, stall_cnt, core_gnt_cyc, first_x_after, rv_cnt;
    bit core_pending, core_done, core_rd_due;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 16'h0000;
        ram[10'h010] = 16'hBEEF;
        ram[10'h050] = 16'h5050;
        ram[10'h061] = 16'h6161;
        ram[10'h070] = 16'h7070;
        ram[10'h071] = 16'h7171;
        ram[10'h090] = 16'h9090;
        for (int i = 0; i < 8; i++) ram[10'h100 + i] = 16'hC000 + 16'(i);

        //          cl cw ca      cwd       cc      xr xw xa      xwd       xg st we re addr    wd        ctrl
        vecs[0] = '{0, 0, 10'h000, 16'h0000, 3'b000, 0, 0, 10'h000, 16'h0000, 0, 0, 0, 0, 10'h000, 16'h0000, 3'b000};
        vecs[1] = '{0, 1, 10'h020, 16'h1234, 3'b010, 0, 0, 10'h000, 16'h0000, 0, 0, 1, 0, 10'h020, 16'h1234, 3'b010};
        vecs[2] = '{0, 0, 10'h000, 16'h0000, 3'b000, 1, 0, 10'h030, 16'h0000, 1, 0, 0, 1, 10'h030, 16'h0000, 3'b000};
        vecs[3] = '{0, 0, 10'h000, 16'h0000, 3'b000, 1, 1, 10'h031, 16'hAAAA, 1, 0, 1, 0, 10'h031, 16'hAAAA, 3'b000};
        vecs[4] = '{1, 1, 10'h040, 16'h5555, 3'b001, 0, 0, 10'h000, 16'h0000, 0, 0, 1, 0, 10'h040, 16'h5555, 3'b001};
        vecs[5] = '{1, 0, 10'h041, 16'h0000, 3'b011, 0, 0, 10'h000, 16'h0000, 0, 0, 0, 1, 10'h041, 16'h0000, 3'b011};
        vecs[6] = '{0, 0, 10'h000, 16'h0000, 3'b000, 0, 0, 10'h000, 16'h0000, 0, 0, 0, 0, 10'h000, 16'h0000, 3'b000};
        vecs[7] = '{0, 0, 10'h000, 16'h0000, 3'b000, 1, 0, 10'h033, 16'h0000, 1, 0, 0, 1, 10'h033, 16'h0000, 3'b000};
        vecs[8] = '{1, 0, 10'h043, 16'h0000, 3'b101, 1, 0, 10'h034, 16'h0000, 1, 1, 0, 1, 10'h034, 16'h0000, 3'b000};
        vecs[9] = '{1, 0, 10'h043, 16'h0000, 3'b101, 0, 0, 10'h000, 16'h0000, 0, 0, 0, 1, 10'h043, 16'h0000, 3'b101};

        // Reset state, then ten idle cycles.
        idle_inputs();
        #1;
        check("reset_x_rvalid", 32'(x_rvalid), 0);
        check("reset_core_rdata", 32'(core_rdata), 0);
        check("reset_x_rdata", 32'(x_rdata), 0);
        check("reset_mem_we", 32'(mem_we), 0);
        do_reset();
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            @(negedge clk);
            check($sformatf("idle%0d_mem_we", c), 32'(mem_we), 0);
            check($sformatf("idle%0d_mem_re", c), 32'(mem_re), 0);
            check($sformatf("idle%0d_core_stall", c), 32'(core_stall), 0);
            check($sformatf("idle%0d_x_gnt", c), 32'(x_gnt), 0);
        end

        // Cycle table, state carried from row to row.
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            core_load  = vecs[i].cl;
            core_write = vecs[i].cw;
            core_addr  = vecs[i].ca;
            core_wdata = vecs[i].cwd;
            core_ctrl  = vecs[i].cc;
            x_req      = vecs[i].xr;
            x_we       = vecs[i].xw;
            x_addr     = vecs[i].xa;
            x_wdata    = vecs[i].xwd;
            @(negedge clk);
            check($sformatf("vec%0d_x_gnt", i), 32'(x_gnt), 32'(vecs[i].e_xg));
            check($sformatf("vec%0d_core_stall", i), 32'(core_stall), 32'(vecs[i].e_st));
            check($sformatf("vec%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
            check($sformatf("vec%0d_mem_re", i), 32'(mem_re), 32'(vecs[i].e_re));
            check($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
            check($sformatf("vec%0d_mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].e_wd));
            check($sformatf("vec%0d_mem_ctrl", i), 32'(mem_ctrl), 32'(vecs[i].e_ctrl));
        end

        // Core load with one-cycle read return.
        do_reset();
        next_cycle();
        core_load = 1'b1; core_addr = 10'h010; core_ctrl = 3'b001;
        @(negedge clk);
        check("cload_mem_re", 32'(mem_re), 1);
        check("cload_mem_addr", 32'(mem_addr), 32'h010);
        check("cload_stall", 32'(core_stall), 0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("cload_core_rdata", 32'(core_rdata), 32'hBEEF);
        check("cload_x_rvalid", 32'(x_rvalid), 0);
        next_cycle();
        @(negedge clk);
        check("cload_core_rdata_hold", 32'(core_rdata), 32'hBEEF);

        // Core write and external read collide in IDLE.
        do_reset();
        next_cycle();
        core_write = 1'b1; core_addr = 10'h060; core_wdata = 16'h0F0F;
        x_req = 1'b1; x_we = 1'b0; x_addr = 10'h061;
        @(negedge clk);
        check("coll_x_gnt", 32'(x_gnt), 0);
        check("coll_core_stall", 32'(core_stall), 0);
        check("coll_mem_we", 32'(mem_we), 1);
        check("coll_mem_addr", 32'(mem_addr), 32'h060);
        next_cycle();
        core_write = 1'b0;
        @(negedge clk);
        check("coll_next_x_gnt", 32'(x_gnt), 1);
        check("coll_next_mem_addr", 32'(mem_addr), 32'h061);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("coll_x_rvalid", 32'(x_rvalid), 1);
        check("coll_x_rdata", 32'(x_rdata), 32'h6161);

        // Alternating owners on back-to-back reads.
        do_reset();
        next_cycle();
        x_req = 1'b1; x_addr = 10'h070;
        @(negedge clk);
        check("alt_x_gnt", 32'(x_gnt), 1);
        next_cycle();
        x_req = 1'b0; core_load = 1'b1; core_addr = 10'h071;
        @(negedge clk);
        check("alt_core_mem_re", 32'(mem_re), 1);
        check("alt_core_stall", 32'(core_stall), 0);
        check("alt_x_rvalid", 32'(x_rvalid), 1);
        check("alt_x_rdata", 32'(x_rdata), 32'h7070);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("alt_core_rdata", 32'(core_rdata), 32'h7171);
        check("alt_x_rvalid_low", 32'(x_rvalid), 0);
        check("alt_x_rdata_hold", 32'(x_rdata), 32'h7070);

        // Eight external reads with the core waiting from the second one.
        do_reset();
        xdone = 0; gnt_wait = 0; stall_cnt = 0; rv_cnt = 0;
        core_gnt_cyc = -1; first_x_after = -1;
        core_pending = 1'b0; core_done = 1'b0; core_rd_due = 1'b0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            next_cycle();
            if (cyc == 1 && !core_done) core_pending = 1'b1;
            x_req     = (xdone < 8);
            x_we      = 1'b0;
            x_addr    = 10'h100 + 10'(xdone);
            core_load = core_pending;
            core_addr = 10'h050;
            @(negedge clk);
            if (core_rd_due) begin
                check("burst_core_rdata", 32'(core_rdata), 32'h5050);
                core_rd_due = 1'b0;
            end
            if (x_rvalid) begin
                check($sformatf("burst_x_rdata%0d", rv_cnt), 32'(x_rdata), 32'hC000 + 32'(rv_cnt));
                rv_cnt++;
            end
            if (core_stall) stall_cnt++;
            if (x_gnt) begin
                xdone++;
                if (core_load) gnt_wait++;
                if (core_done && first_x_after < 0) first_x_after = cyc;
            end
            if (core_load && !core_stall) begin
                core_gnt_cyc = cyc;
                core_pending = 1'b0;
                core_done    = 1'b1;
                core_rd_due  = 1'b1;
            end
        end
        idle_inputs();
        check("burst_x_grants_while_waiting", 32'(gnt_wait), 4);
        check("burst_stall_cycles", 32'(stall_cnt), 4);
        check("burst_core_grant_cycle", 32'(core_gnt_cyc), 5);
        check("burst_x_resume_cycle", 32'(first_x_after), 6);
        check("burst_x_total", 32'(xdone), 8);
        check("burst_rvalid_total", 32'(rv_cnt), 8);

        // Both requesting continuously.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            core_load = 1'b1; core_addr = 10'h080;
            x_req = 1'b1; x_we = 1'b0; x_addr = 10'h081;
            @(negedge clk);
            check($sformatf("both%0d_x_gnt", i), 32'(x_gnt), 32'(RR && (i % 2 == 1)));
            check($sformatf("both%0d_core_stall", i), 32'(core_stall), 32'(RR && (i % 2 == 1)));
        end

        // Reset asserted right after an external read grant.
        do_reset();
        next_cycle();
        x_req = 1'b1; x_we = 1'b0; x_addr = 10'h090;
        @(negedge clk);
        check("mrst_x_gnt_before", 32'(x_gnt), 1);
        next_cycle();
        rst = 1'b0;
        #1;
        check("mrst_x_rvalid", 32'(x_rvalid), 0);
        check("mrst_x_rdata", 32'(x_rdata), 0);
        check("mrst_x_gnt", 32'(x_gnt), 0);
        check("mrst_mem_re", 32'(mem_re), 0);
        check("mrst_mem_we", 32'(mem_we), 0);
        check("mrst_core_stall", 32'(core_stall), 0);
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            @(negedge clk);
            check($sformatf("mrst_after%0d_x_rvalid", c), 32'(x_rvalid), 0);
            check($sformatf("mrst_after%0d_x_rdata", c), 32'(x_rdata), 0);
        end
        next_cycle();
        core_load = 1'b1; core_addr = 10'h010;
        x_req = 1'b1; x_addr = 10'h090;
        @(negedge clk);
        check("mrst_idle_core_wins_x_gnt", 32'(x_gnt), 0);
        check("mrst_idle_core_wins_stall", 32'(core_stall), 0);
        next_cycle();
        idle_inputs();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
